ps2_gamepad_decoder: RTL and testbench
======================================

// Module: ps2_gamepad_decoder
// PURPOSE
//  Converts a PS/2 keyboard stream into an 8-bit NES controller button vector.
//  Sits upstream of the input-devices logic. ps2_clk_i/ps2_data_i come from the
//  board pins; buttons_o drives the controller-1 input vector used by the CPU.
//  Receives 11-bit PS/2 frames, checks them, and tracks E0/F0 prefixes.
//  Maps make/break codes to button press/release.
// PARAMETERS
//  CLK_FREQ_HZ   100000000  clk_i frequency, used to size the frame timeout
//  TIMEOUT_US    200        max gap between PS/2 clock falls inside a frame
//  SYNC_STAGES   2          flip-flop stages on ps2_clk_i/ps2_data_i (>=2)
// PORTS
//  clk_i          in   1  system clock; one clock domain
//  arstn_i        in   1  asynchronous reset, active-low
//  ps2_clk_i      in   1  raw PS/2 clock from pin (async, idle high)
//  ps2_data_i     in   1  raw PS/2 data from pin (async, idle high)
//  buttons_o      out  8  [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right; 1=pressed
//  scan_valid_o   out  1  1-cycle pulse: valid byte on scan_code_o
//  scan_code_o    out  8  last good received byte (debug)
//  frame_error_o  out  1  1-cycle pulse: parity, stop or timeout error
// BEHAVIOUR
//  Interface: one clock (clk_i). Reset arstn_i is asynchronous and active-low.
//  Reset: all outputs 0. Receiver in IDLE. Prefix flags cleared.
//   Sync registers reset to 1, so no false falling edge is seen after reset.
//  Edge detect: a fall is synced ps2_clk 1->0. Data is sampled on the same cycle.
//  Receiver FSM (sub-module), one bit per fall:
//   IDLE   -> DATA   on fall with data=0 (start bit). data=1 is ignored.
//   DATA   -> PARITY after 8 bits, LSB first, shifted into an 8-bit register.
//   PARITY -> STOP   after 1 bit. Required: XOR(data, parity) = 1 (odd parity).
//   STOP   -> IDLE   after 1 bit. Stop=1 and parity ok -> pulse byte_valid.
//                    Otherwise pulse error and discard the byte.
//  Timeout: counter = CLK_FREQ_HZ/1e6*TIMEOUT_US cycles (20000 at defaults).
//   Reloaded on every fall. Runs only outside IDLE.
//   Expiry -> error pulse, FSM to IDLE, partial byte discarded.
//  scan_valid_o/scan_code_o: registered, one clk after the stop-bit fall.
//  Decoder acts on the cycle of scan_valid_o. buttons_o updates the next clk.
//   Total: 2 clks from stop-bit fall to buttons_o.
//  Decoder byte handling:
//   E0 -> ext=1.
//   F0 -> brk=1.
//   Any other byte -> look up (ext, code), then clear ext and brk.
//     If mapped, the button bit <= ~brk. If unmapped, buttons_o is unchanged.
//  Key map:
//   A=22(X), B=1A(Z), Select=59(RShift), Start=5A(Enter).
//   Up=E0 75, Down=E0 72, Left=E0 6B, Right=E0 74.
//   Non-extended 75/72/6B/74 (keypad) are unmapped.
//   E1 (Pause) has no special handling; its bytes fall through as unmapped.
//  Boundaries:
//   frame_error clears ext and brk. Repeated make codes are idempotent.
//   Break for a key that is not held is harmless.
//   Async reset mid-frame aborts the frame and releases all buttons.
//   A fall arriving on the timeout-expiry cycle: expiry wins. That fall is
//     then evaluated from IDLE.
// CONFIGURATION
//  PS2_SOCD_FILTER_EN defined:
//   buttons_o[4]/[5] both 0 while Up and Down are both held.
//   buttons_o[6]/[7] both 0 while Left and Right are both held.
//   The internal held-state is kept unfiltered. Filter output is combinational
//     on the held-state register; no added latency.
//  Not defined: buttons_o = raw held-state.
// STRUCTURE
//  Package nes_input_pkg:
//   button index constants BTN_A..BTN_RIGHT.
//   scan code constants SC_EXT=E0, SC_BRK=F0 and the 8 key codes.
//   receiver state typedef (IDLE, DATA, PARITY, STOP).
//  Sub-module ps2_frame_receiver contains:
//   synchroniser, edge detect, FSM, timeout counter.
//   outputs byte/byte_valid/error.
//  Top of this block: prefix flags, map lookup, held-state register, optional filter.
// TESTING
//  Frame 0x22 with good parity -> scan_valid_o pulse, scan_code_o=22, buttons_o=01.
//   Then F0 22 -> buttons_o=00.
//  E0 75 -> buttons_o[4]=1. Plain 75 -> buttons_o unchanged.
//   E0 F0 75 -> buttons_o[4]=0.
//  Frame 0x5A with a bad parity bit -> frame_error_o pulse, no scan_valid_o,
//   buttons_o unchanged. Next good 5A -> buttons_o[3]=1.
//  Stop after 5 data bits for >20000 clks -> one frame_error_o pulse.
//   Next full frame 1A -> buttons_o[1]=1.
//  With PS2_SOCD_FILTER_EN: E0 6B then E0 74 -> buttons_o[7:6]=00.
//   Then E0 F0 6B -> buttons_o[7:6]=10.
//   Without the macro, the same sequence gives 11 then 10.
//  Assert arstn_i mid-frame with A held -> buttons_o=00 immediately.
//   After release, a full frame decodes correctly.

Source files
------------

// File: rtl/nes_input_pkg.sv
// Shared constants for the PS/2-to-NES gamepad path: button bit positions,
// scan codes, receiver state encoding and the scan-code-to-button lookup.
package nes_input_pkg;

    // Bit positions in the NES controller vector (1 = pressed)
    localparam logic [2:0] BTN_A      = 3'd0;
    localparam logic [2:0] BTN_B      = 3'd1;
    localparam logic [2:0] BTN_SELECT = 3'd2;
    localparam logic [2:0] BTN_START  = 3'd3;
    localparam logic [2:0] BTN_UP     = 3'd4;
    localparam logic [2:0] BTN_DOWN   = 3'd5;
    localparam logic [2:0] BTN_LEFT   = 3'd6;
    localparam logic [2:0] BTN_RIGHT  = 3'd7;

    // Prefix bytes
    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    // Key codes (arrow keys are only meaningful after SC_EXT)
    localparam logic [7:0] SC_KEY_A      = 8'h22;
    localparam logic [7:0] SC_KEY_B      = 8'h1A;
    localparam logic [7:0] SC_KEY_SELECT = 8'h59;
    localparam logic [7:0] SC_KEY_START  = 8'h5A;
    localparam logic [7:0] SC_KEY_UP     = 8'h75;
    localparam logic [7:0] SC_KEY_DOWN   = 8'h72;
    localparam logic [7:0] SC_KEY_LEFT   = 8'h6B;
    localparam logic [7:0] SC_KEY_RIGHT  = 8'h74;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } key_map_t;

    // Map (extended flag, code) to a button; non-extended arrow codes are
    // keypad keys and deliberately stay unmapped.
    function automatic key_map_t map_key(input logic ext, input logic [7:0] code);
        key_map_t m;
        m.hit = 1'b1;
        m.idx = BTN_A;
        case ({ext, code})
            {1'b0, SC_KEY_A}:      m.idx = BTN_A;
            {1'b0, SC_KEY_B}:      m.idx = BTN_B;
            {1'b0, SC_KEY_SELECT}: m.idx = BTN_SELECT;
            {1'b0, SC_KEY_START}:  m.idx = BTN_START;
            {1'b1, SC_KEY_UP}:     m.idx = BTN_UP;
            {1'b1, SC_KEY_DOWN}:   m.idx = BTN_DOWN;
            {1'b1, SC_KEY_LEFT}:   m.idx = BTN_LEFT;
            {1'b1, SC_KEY_RIGHT}:  m.idx = BTN_RIGHT;
            default:               m.hit = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_frame_receiver.sv
// PS/2 frame receiver: synchroniser, falling-edge detect, start/data/parity/
// stop FSM and inter-edge timeout. Emits one-cycle byte_valid/error pulses.
module ps2_frame_receiver
    import nes_input_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int TIMEOUT_US  = 200,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       arstn_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       error_o
);

    localparam int TIMEOUT_CYCLES = CLK_FREQ_HZ / 1000000 * TIMEOUT_US;
    localparam int TW             = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync_reg;
    logic [SYNC_STAGES-1:0] data_sync_reg;
    logic                   clk_prev_reg;
    rx_state_t              state_reg, state_next;
    logic [7:0]             shift_reg;
    logic [2:0]             bit_cnt_reg;
    logic                   parity_ok_reg;
    logic [TW-1:0]          timeout_cnt_reg;
    logic [7:0]             code_reg;
    logic                   byte_valid_reg;
    logic                   error_reg;

    logic ps2_clk_s, ps2_data_s, fall, expire;
    logic start_bit, shift_en, parity_en, stop_en, frame_ok;

    // Synchronisers idle at 1 so reset release never looks like a falling edge
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            clk_sync_reg  <= '1;
            data_sync_reg <= '1;
            clk_prev_reg  <= 1'b1;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], ps2_clk_i};
            data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], ps2_data_i};
            clk_prev_reg  <= ps2_clk_s;
        end
    end

    assign ps2_clk_s  = clk_sync_reg[SYNC_STAGES-1];
    assign ps2_data_s = data_sync_reg[SYNC_STAGES-1];
    assign fall       = clk_prev_reg & ~ps2_clk_s;
    // Expiry takes priority over a coincident fall; that fall is seen from IDLE
    assign expire     = (state_reg != RX_IDLE) && (timeout_cnt_reg == '0);

    // FSM state register
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) state_reg <= RX_IDLE;
        else          state_reg <= state_next;
    end

    // FSM next-state logic: one step per PS/2 clock fall
    always_comb begin
        state_next = state_reg;
        if (expire) begin
            state_next = (fall && !ps2_data_s) ? RX_DATA : RX_IDLE;
        end else if (fall) begin
            case (state_reg)
                RX_IDLE:   if (!ps2_data_s) state_next = RX_DATA;
                RX_DATA:   if (bit_cnt_reg == 3'd7) state_next = RX_PARITY;
                RX_PARITY: state_next = RX_STOP;
                RX_STOP:   state_next = RX_IDLE;
                default:   state_next = RX_IDLE;
            endcase
        end
    end

    // FSM output decode: per-bit datapath strobes
    always_comb begin
        start_bit = fall && !ps2_data_s && ((state_reg == RX_IDLE) || expire);
        shift_en  = fall && !expire && (state_reg == RX_DATA);
        parity_en = fall && !expire && (state_reg == RX_PARITY);
        stop_en   = fall && !expire && (state_reg == RX_STOP);
        frame_ok  = ps2_data_s && parity_ok_reg;
    end

    // Datapath: shifter, bit counter, parity check, timeout and result pulses
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            shift_reg       <= '0;
            bit_cnt_reg     <= '0;
            parity_ok_reg   <= 1'b0;
            timeout_cnt_reg <= '0;
            code_reg        <= '0;
            byte_valid_reg  <= 1'b0;
            error_reg       <= 1'b0;
        end else begin
            if (fall)
                timeout_cnt_reg <= TW'(TIMEOUT_CYCLES);
            else if (state_reg != RX_IDLE && timeout_cnt_reg != '0)
                timeout_cnt_reg <= timeout_cnt_reg - TW'(1);
            if (start_bit)
                bit_cnt_reg <= '0;
            if (shift_en) begin
                shift_reg   <= {ps2_data_s, shift_reg[7:1]};
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
            if (parity_en)
                parity_ok_reg <= ^{shift_reg, ps2_data_s};
            byte_valid_reg <= stop_en && frame_ok;
            error_reg      <= expire || (stop_en && !frame_ok);
            if (stop_en && frame_ok)
                code_reg <= shift_reg;
        end
    end

    assign byte_o       = code_reg;
    assign byte_valid_o = byte_valid_reg;
    assign error_o      = error_reg;

endmodule

// File: rtl/ps2_gamepad_decoder.sv
// PS/2 keyboard to NES controller vector. Tracks E0/F0 prefixes, maps keys
// to buttons and holds their state. Optional SOCD filter: PS2_SOCD_FILTER_EN.
module ps2_gamepad_decoder
    import nes_input_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int TIMEOUT_US  = 200,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       arstn_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] buttons_o,
    output logic       scan_valid_o,
    output logic [7:0] scan_code_o,
    output logic       frame_error_o
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_error;
    logic       ext_reg;
    logic       brk_reg;
    logic [7:0] held_reg;
    key_map_t   key;

    ps2_frame_receiver #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .TIMEOUT_US  (TIMEOUT_US),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .clk_i        (clk_i),
        .arstn_i      (arstn_i),
        .ps2_clk_i    (ps2_clk_i),
        .ps2_data_i   (ps2_data_i),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .error_o      (rx_error)
    );

    assign key = map_key(ext_reg, rx_byte);

    // Prefix tracking and held-button state, acting on each received byte
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            ext_reg  <= 1'b0;
            brk_reg  <= 1'b0;
            held_reg <= '0;
        end else if (rx_error) begin
            ext_reg <= 1'b0;
            brk_reg <= 1'b0;
        end else if (rx_valid) begin
            if (rx_byte == SC_EXT) begin
                ext_reg <= 1'b1;
            end else if (rx_byte == SC_BRK) begin
                brk_reg <= 1'b1;
            end else begin
                if (key.hit)
                    held_reg[key.idx] <= ~brk_reg;
                ext_reg <= 1'b0;
                brk_reg <= 1'b0;
            end
        end
    end

`ifdef PS2_SOCD_FILTER_EN
    // Opposing directions held together cancel; held_reg stays unfiltered
    always_comb begin
        buttons_o = held_reg;
        if (held_reg[BTN_UP] && held_reg[BTN_DOWN]) begin
            buttons_o[BTN_UP]   = 1'b0;
            buttons_o[BTN_DOWN] = 1'b0;
        end
        if (held_reg[BTN_LEFT] && held_reg[BTN_RIGHT]) begin
            buttons_o[BTN_LEFT]  = 1'b0;
            buttons_o[BTN_RIGHT] = 1'b0;
        end
    end
`else
    assign buttons_o = held_reg;
`endif

    assign scan_valid_o  = rx_valid;
    assign scan_code_o   = rx_byte;
    assign frame_error_o = rx_error;

endmodule

// File: tb/tb_ps2_gamepad_decoder.sv
// Directed bench for ps2_gamepad_decoder: drives PS/2 frames on the pins and
// checks buttons, scan outputs and error pulses against hand-computed values.
module tb_ps2_gamepad_decoder;

    logic       clk_i = 1'b0;
    logic       arstn_i = 1'b0;
    logic       ps2_clk_i = 1'b1;
    logic       ps2_data_i = 1'b1;
    logic [7:0] buttons_o;
    logic       scan_valid_o;
    logic [7:0] scan_code_o;
    logic       frame_error_o;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int v0, e0;

    localparam int HALF = 10;  // system clocks per PS/2 half bit

    ps2_gamepad_decoder dut (
        .clk_i         (clk_i),
        .arstn_i       (arstn_i),
        .ps2_clk_i     (ps2_clk_i),
        .ps2_data_i    (ps2_data_i),
        .buttons_o     (buttons_o),
        .scan_valid_o  (scan_valid_o),
        .scan_code_o   (scan_code_o),
        .frame_error_o (frame_error_o)
    );

    always #5 clk_i = ~clk_i;

    // Pulse counters for scan_valid_o / frame_error_o
    always @(posedge clk_i) begin
        if (scan_valid_o)  valid_cnt <= valid_cnt + 1;
        if (frame_error_o) err_cnt   <= err_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b, input logic bad);
        return {1'b1, (~^b) ^ bad, b, 1'b0};
    endfunction

    // Send the first n bits of an 11-bit frame, LSB (start) first
    task automatic send_raw(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            ps2_data_i = bits[i];
            repeat (HALF) @(negedge clk_i);
            ps2_clk_i = 1'b0;
            repeat (HALF) @(negedge clk_i);
            ps2_clk_i = 1'b1;
        end
        ps2_data_i = 1'b1;
        repeat (2 * HALF) @(negedge clk_i);
    endtask

    task automatic send(input logic [7:0] b);
        send_raw(frame(b, 1'b0), 11);
    endtask

    task automatic snap();
        v0 = valid_cnt;
        e0 = err_cnt;
    endtask

    initial begin
        logic [7:0] lr_both;
        // Reset state
        repeat (3) @(negedge clk_i);
        chk("rst_buttons", buttons_o, 8'h00);
        chk("rst_valid", scan_valid_o, 1'b0);
        chk("rst_code", scan_code_o, 8'h00);
        chk("rst_error", frame_error_o, 1'b0);
        arstn_i = 1'b1;
        repeat (5) @(negedge clk_i);

        // A make
        snap();
        send(8'h22);
        chk("a_make_valid", valid_cnt - v0, 1);
        chk("a_make_err", err_cnt - e0, 0);
        chk("a_make_code", scan_code_o, 8'h22);
        chk("a_make_btn", buttons_o, 8'h01);

        // A break
        send(8'hF0); send(8'h22);
        chk("a_break_btn", buttons_o, 8'h00);

        // Extended Up, keypad 8 ignored, extended Up release
        send(8'hE0); send(8'h75);
        chk("up_make", buttons_o, 8'h10);
        send(8'h75);
        chk("kp_unmapped", buttons_o, 8'h10);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("up_break", buttons_o, 8'h00);

        // Bad parity Start is dropped, then good Start
        snap();
        send_raw(frame(8'h5A, 1'b1), 11);
        chk("badpar_err", err_cnt - e0, 1);
        chk("badpar_valid", valid_cnt - v0, 0);
        chk("badpar_btn", buttons_o, 8'h00);
        chk("badpar_code", scan_code_o, 8'h75);
        send(8'h5A);
        chk("start_make", buttons_o, 8'h08);

        // Truncated frame (start + 5 data bits) times out once
        snap();
        send_raw(frame(8'h1A, 1'b0), 6);
        repeat (20500) @(negedge clk_i);
        chk("timeout_err", err_cnt - e0, 1);
        chk("timeout_valid", valid_cnt - v0, 0);
        chk("timeout_btn", buttons_o, 8'h08);
        send(8'h1A);
        chk("b_make", buttons_o, 8'h0A);

        // Left then Right held together
`ifdef PS2_SOCD_FILTER_EN
        lr_both = 8'h0A;
`else
        lr_both = 8'hCA;
`endif
        send(8'hE0); send(8'h6B);
        chk("left_make", buttons_o, 8'h4A);
        send(8'hE0); send(8'h74);
        chk("left_right", buttons_o, lr_both);
        send(8'hE0); send(8'hF0); send(8'h6B);
        chk("left_break", buttons_o, 8'h8A);

        // Break of unheld key and repeated make are harmless
        send(8'hF0); send(8'h22);
        chk("break_unheld", buttons_o, 8'h8A);
        send(8'h1A);
        chk("repeat_make", buttons_o, 8'h8A);

        // Frame error clears pending E0 and F0
        send(8'hE0);
        send_raw(frame(8'h00, 1'b1), 11);
        send(8'h75);
        chk("err_clr_ext", buttons_o, 8'h8A);
        send(8'hF0);
        send_raw(frame(8'h00, 1'b1), 11);
        send(8'h1A);
        chk("err_clr_brk", buttons_o, 8'h8A);

        // Async reset mid-frame releases everything immediately
        send(8'h22);
        chk("a_again", buttons_o, 8'h8B);
        send_raw(frame(8'h5A, 1'b0), 4);
        #2 arstn_i = 1'b0;
        #1;
        chk("rst_mid_btn", buttons_o, 8'h00);
        repeat (3) @(negedge clk_i);
        arstn_i = 1'b1;
        repeat (5) @(negedge clk_i);
        snap();
        send(8'h22);
        chk("post_rst_valid", valid_cnt - v0, 1);
        chk("post_rst_btn", buttons_o, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
